// File: rtl/gc_transmit_if.sv
// Controller-line transmit bundle between the receiver control logic and gc_transmit.
// The slave modport is the transmitter side.
interface gc_transmit_if;
   logic start_init;
   logic rumble;
   logic wavebird_id_ready;
   logic data_oe;
   logic send;
   logic controller_init;
   logic busy;

   modport master (
      output start_init, rumble, wavebird_id_ready,
      input  data_oe, send, controller_init, busy
   );

   modport slave (
      input  start_init, rumble, wavebird_id_ready,
      output data_oe, send, controller_init, busy
   );
endinterface

// File: rtl/gc_transmit.sv
// GameCube controller line transmitter: periodic poll frames and on-demand init frames,
// open-drain drive, with send/controller_init hints for the downstream receiver.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// S_IDLE     | line released, waiting for init request or poll due
// S_LOAD     | frame latched, send raised, line still released
// S_BIT_LOW  | line pulled low: 3 us for a 0 bit, 1 us for a 1 bit
// S_BIT_HIGH | line released for the rest of the 4 us bit cell
// S_STOP_LOW | stop bit, line low for 1 us
// S_GUARD    | line released, send held for the receiver synchroniser
module gc_transmit #(
   parameter int unsigned CLKS_PER_US    = 100,
   parameter int unsigned POLL_PERIOD_US = 1000,
   parameter logic [23:0] POLL_CMD       = 24'h400300,
   parameter logic [7:0]  INIT_CMD       = 8'h00,
   parameter int unsigned SYNC_GUARD     = 2
) (
   input logic          PCLK,
   input logic          PRESERN,
   gc_transmit_if.slave bus
);

   localparam int unsigned PS_W    = $clog2(CLKS_PER_US);
   localparam int unsigned PT_W    = $clog2(POLL_PERIOD_US + 1);
   localparam int unsigned INIT_TO = POLL_PERIOD_US * CLKS_PER_US;
   localparam int unsigned IT_W    = $clog2(INIT_TO + 1);
   localparam int unsigned PH_MAX  = (3 * CLKS_PER_US > SYNC_GUARD) ? 3 * CLKS_PER_US : SYNC_GUARD;
   localparam int unsigned PH_W    = $clog2(PH_MAX + 1);
   localparam int unsigned GUARD_N = (SYNC_GUARD > 0) ? SYNC_GUARD - 1 : 0;

   localparam logic [PS_W-1:0] PS_LAST  = PS_W'(CLKS_PER_US - 1);
   localparam logic [PT_W-1:0] PT_LAST  = PT_W'(POLL_PERIOD_US - 1);
   localparam logic [IT_W-1:0] IT_LOAD  = IT_W'(INIT_TO - 1);
   localparam logic [PH_W-1:0] PH_1US   = PH_W'(CLKS_PER_US - 1);
   localparam logic [PH_W-1:0] PH_3US   = PH_W'(3 * CLKS_PER_US - 1);
   localparam logic [PH_W-1:0] PH_GUARD = PH_W'(GUARD_N);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_LOAD     = 3'd1;
   localparam logic [2:0] S_BIT_LOW  = 3'd2;
   localparam logic [2:0] S_BIT_HIGH = 3'd3;
   localparam logic [2:0] S_STOP_LOW = 3'd4;
   localparam logic [2:0] S_GUARD    = 3'd5;

   logic [2:0]      state;
   logic [PS_W-1:0] presc;
   logic [PT_W-1:0] poll_tmr;
   logic [IT_W-1:0] init_tmr;
   logic [PH_W-1:0] ph_cnt;
   logic [4:0]      bit_cnt;
   logic [23:0]     shreg;
   logic            poll_due;
   logic            init_pending;
   logic            ctrl_init;
   logic            send_q;
   logic            oe_q;

   logic us_tick;
   logic poll_hit;
   logic init_req;
   logic load_init;
   logic load_poll;
   logic ph_done;
   logic frame_end;
   logic init_clear;

   always_comb begin
      us_tick    = (presc == PS_LAST);
      poll_hit   = us_tick && (poll_tmr == PT_LAST);
      // a start_init arriving in the same cycle as a poll still wins arbitration
      init_req   = init_pending || (bus.start_init && !ctrl_init);
      load_init  = (state == S_IDLE) && init_req;
      load_poll  = (state == S_IDLE) && !init_req && !ctrl_init && (poll_due || poll_hit);
      ph_done    = (ph_cnt == '0);
      frame_end  = (state == S_GUARD) && ph_done;
      init_clear = ctrl_init && !send_q && (bus.wavebird_id_ready || (init_tmr == '0));
   end

   always_ff @(posedge PCLK or negedge PRESERN) begin
      if (!PRESERN) begin
         presc        <= '0;
         poll_tmr     <= '0;
         poll_due     <= 1'b0;
         init_pending <= 1'b0;
      end else begin
         if (load_init || load_poll || us_tick) presc <= '0;
         else                                   presc <= presc + 1'b1;

         if (us_tick) poll_tmr <= (poll_tmr == PT_LAST) ? '0 : poll_tmr + 1'b1;

         if (load_poll)     poll_due <= 1'b0;
         else if (poll_hit) poll_due <= 1'b1;

         if (load_init)                             init_pending <= 1'b0;
         else if (bus.start_init && !ctrl_init)     init_pending <= 1'b1;
      end
   end

   always_ff @(posedge PCLK or negedge PRESERN) begin
      if (!PRESERN) begin
         ctrl_init <= 1'b0;
         init_tmr  <= '0;
      end else begin
         if (load_init)       ctrl_init <= 1'b1;
         else if (init_clear) ctrl_init <= 1'b0;

         // timeout is measured in clocks from the falling edge of send
         if (frame_end && ctrl_init)                         init_tmr <= IT_LOAD;
         else if (ctrl_init && !send_q && init_tmr != '0)    init_tmr <= init_tmr - 1'b1;
      end
   end

   always_ff @(posedge PCLK or negedge PRESERN) begin
      if (!PRESERN) begin
         state   <= S_IDLE;
         ph_cnt  <= '0;
         bit_cnt <= '0;
         shreg   <= '0;
         send_q  <= 1'b0;
         oe_q    <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (load_init) begin
                  state   <= S_LOAD;
                  send_q  <= 1'b1;
                  shreg   <= {INIT_CMD, 16'h0000};
                  bit_cnt <= 5'd8;
               end else if (load_poll) begin
                  state   <= S_LOAD;
                  send_q  <= 1'b1;
                  shreg   <= {POLL_CMD[23:1], bus.rumble};
                  bit_cnt <= 5'd24;
               end
            end
            S_LOAD: begin
               state  <= S_BIT_LOW;
               oe_q   <= 1'b1;
               ph_cnt <= shreg[23] ? PH_1US : PH_3US;
            end
            S_BIT_LOW: begin
               if (ph_done) begin
                  state  <= S_BIT_HIGH;
                  oe_q   <= 1'b0;
                  ph_cnt <= shreg[23] ? PH_3US : PH_1US;
               end else begin
                  ph_cnt <= ph_cnt - 1'b1;
               end
            end
            S_BIT_HIGH: begin
               if (ph_done) begin
                  shreg   <= {shreg[22:0], 1'b0};
                  bit_cnt <= bit_cnt - 1'b1;
                  oe_q    <= 1'b1;
                  if (bit_cnt == 5'd1) begin
                     state  <= S_STOP_LOW;
                     ph_cnt <= PH_1US;
                  end else begin
                     state  <= S_BIT_LOW;
                     ph_cnt <= shreg[22] ? PH_1US : PH_3US;
                  end
               end else begin
                  ph_cnt <= ph_cnt - 1'b1;
               end
            end
            S_STOP_LOW: begin
               if (ph_done) begin
                  state  <= S_GUARD;
                  oe_q   <= 1'b0;
                  ph_cnt <= PH_GUARD;
               end else begin
                  ph_cnt <= ph_cnt - 1'b1;
               end
            end
            S_GUARD: begin
               if (ph_done) begin
                  state  <= S_IDLE;
                  send_q <= 1'b0;
               end else begin
                  ph_cnt <= ph_cnt - 1'b1;
               end
            end
            default: begin
               state  <= S_IDLE;
               oe_q   <= 1'b0;
               send_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.data_oe         = oe_q;
   assign bus.send            = send_q;
   assign bus.controller_init = ctrl_init;
   assign bus.busy            = (state != S_IDLE);

endmodule

// File: tb/tb_gc_transmit.sv
// Directed bench for gc_transmit with CLKS_PER_US=4, POLL_PERIOD_US=200.
// Timing expectations are hand-computed edge counts from reset release.
module tb_gc_transmit;
   logic PCLK = 1'b0;
   logic PRESERN;

   gc_transmit_if bus ();

   gc_transmit #(
      .CLKS_PER_US(4),
      .POLL_PERIOD_US(200),
      .POLL_CMD(24'h400300),
      .INIT_CMD(8'h00),
      .SYNC_GUARD(2)
   ) dut (
      .PCLK(PCLK),
      .PRESERN(PRESERN),
      .bus(bus)
   );

   always #5 PCLK = ~PCLK;

   int errors = 0;
   int checks = 0;
   int lows [0:31];
   int nlows;
   int send_len;
   logic oe_bad = 1'b0;

   always @(negedge PCLK) if (bus.data_oe === 1'b1 && bus.send !== 1'b1) oe_bad = 1'b1;

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic wait_send(input int max, output int n);
      n = 0;
      do begin
         @(negedge PCLK);
         n++;
      end while (bus.send !== 1'b1 && n < max);
   endtask

   // count cycles until controller_init drops; report whether send rose meanwhile
   task automatic wait_init_drop(input int max, output int n, output int saw_send);
      n = 0;
      saw_send = 0;
      do begin
         @(negedge PCLK);
         n++;
         if (bus.send === 1'b1) saw_send = 1;
      end while (bus.controller_init === 1'b1 && n < max);
   endtask

   // called at a negedge with send high; act_kind 1 toggles rumble, 2 pulses start_init
   task automatic measure(input int act_at, input int act_kind);
      int run;
      for (int i = 0; i < 32; i++) lows[i] = 0;
      nlows = 0;
      run = 0;
      send_len = 0;
      while (bus.send === 1'b1 && send_len < 2000) begin
         send_len++;
         if (bus.data_oe === 1'b1) run++;
         else if (run > 0) begin
            if (nlows < 32) lows[nlows] = run;
            nlows++;
            run = 0;
         end
         if (send_len == act_at) begin
            if (act_kind == 1) bus.rumble = ~bus.rumble;
            else if (act_kind == 2) bus.start_init = 1'b1;
         end
         if (act_kind == 2 && send_len == act_at + 1) bus.start_init = 1'b0;
         @(negedge PCLK);
      end
      if (run > 0) begin
         if (nlows < 32) lows[nlows] = run;
         nlows++;
      end
   endtask

   task automatic check_frame(input string tag, input logic [23:0] cmd, input int nbits);
      chk({tag, ".runs"}, nlows, nbits + 1);
      for (int i = 0; i < nbits; i++)
         chk($sformatf("%s.bit%0d", tag, i), lows[i], cmd[23-i] ? 4 : 12);
      chk({tag, ".stop"}, lows[nbits], 4);
      chk({tag, ".send_len"}, send_len, 1 + nbits * 16 + 4 + 2);
   endtask

   initial begin
      int n;
      int saw;
      PRESERN = 1'b0;
      bus.start_init = 1'b0;
      bus.rumble = 1'b0;
      bus.wavebird_id_ready = 1'b0;
      repeat (3) @(negedge PCLK);
      chk("rst.data_oe", int'(bus.data_oe), 0);
      chk("rst.send", int'(bus.send), 0);
      chk("rst.controller_init", int'(bus.controller_init), 0);
      chk("rst.busy", int'(bus.busy), 0);
      PRESERN = 1'b1;

      // first poll, rumble 0
      wait_send(2000, n);
      chk("poll1.start", n, 800);
      chk("poll1.busy", int'(bus.busy), 1);
      measure(0, 0);
      check_frame("poll1", 24'h400300, 24);
      chk("idle.busy", int'(bus.busy), 0);

      // rumble latched at load, toggled mid-frame without effect
      bus.rumble = 1'b1;
      wait_send(2000, n);
      chk("poll2.start", n, 409);
      measure(200, 1);
      check_frame("poll2", 24'h400301, 24);
      bus.rumble = 1'b0;

      // init frame, ID reply 50 cycles after send falls
      bus.start_init = 1'b1;
      @(negedge PCLK);
      bus.start_init = 1'b0;
      chk("init1.send", int'(bus.send), 1);
      chk("init1.controller_init", int'(bus.controller_init), 1);
      measure(0, 0);
      check_frame("init1", 24'h000000, 8);
      saw = 0;
      repeat (50) begin
         @(negedge PCLK);
         if (bus.send === 1'b1) saw = 1;
      end
      chk("init1.hold", int'(bus.controller_init), 1);
      chk("init1.no_poll", saw, 0);
      bus.wavebird_id_ready = 1'b1;
      @(negedge PCLK);
      bus.wavebird_id_ready = 1'b0;
      chk("init1.id_clear", int'(bus.controller_init), 0);
      wait_send(2000, n);
      chk("poll3.start", n, 222);
      measure(0, 0);
      check_frame("poll3", 24'h400300, 24);

      // init frame with no ID reply: timeout then queued poll
      bus.start_init = 1'b1;
      @(negedge PCLK);
      bus.start_init = 1'b0;
      chk("init2.controller_init", int'(bus.controller_init), 1);
      measure(0, 0);
      chk("init2.send_len", send_len, 135);
      wait_init_drop(3000, n, saw);
      chk("init2.timeout", n, 800);
      chk("init2.no_poll", saw, 0);
      wait_send(100, n);
      chk("poll4.start", n, 1);
      measure(0, 0);
      check_frame("poll4", 24'h400300, 24);

      // poll_due already set: start_init on the same cycle goes first; repeat ignored
      bus.start_init = 1'b1;
      @(negedge PCLK);
      bus.start_init = 1'b0;
      chk("init3.first", int'(bus.controller_init), 1);
      chk("init3.send", int'(bus.send), 1);
      measure(40, 2);
      check_frame("init3", 24'h000000, 8);
      wait_init_drop(3000, n, saw);
      chk("init3.timeout", n, 800);
      chk("init3.no_second_frame", saw, 0);
      wait_send(100, n);
      chk("poll5.start", n, 1);
      measure(0, 0);
      check_frame("poll5", 24'h400300, 24);

      // reset in bit 10 of a poll frame
      wait_send(2000, n);
      chk("poll6.start", n, 153);
      repeat (165) @(negedge PCLK);
      chk("poll6.bit10_low", int'(bus.data_oe), 1);
      #1 PRESERN = 1'b0;
      #1;
      chk("rst_mid.data_oe", int'(bus.data_oe), 0);
      chk("rst_mid.send", int'(bus.send), 0);
      chk("rst_mid.busy", int'(bus.busy), 0);
      repeat (2) @(negedge PCLK);
      PRESERN = 1'b1;
      wait_send(2000, n);
      chk("poll7.start", n, 800);
      measure(0, 0);
      check_frame("poll7", 24'h400300, 24);

      chk("oe_needs_send", int'(oe_bad), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
